tdm_demux: RTL

- Receives a time-division-multiplexed sample stream, one sample per valid cycle, with channel 0 marked by a sync flag.
- Steers each sample to its channel slot, then presents all NUM_CH channels in parallel as one frame.
- This is the receive-side counterpart of the select-driven mux path: mux channels onto one wire, demux them back out.

---
 rtl/tdm_demux.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/tdm_demux.sv
`default_nettype none
// ============================================================================
// Module   : tdm_demux
// Purpose  : Splits a sync-marked TDM sample stream back into parallel
//            NUM_CH-channel frames. Optional frame counter: TDM_DEMUX_FRAME_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tdm_demux #(
  parameter  int DATA_W = 8,
  parameter  int NUM_CH = 4,
  localparam int SLOT_W = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic                     in_sync,
  input  logic [DATA_W-1:0]        in_data,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic                     out_valid,
  output logic                     locked,
  output logic                     sync_err,
  output logic [SLOT_W-1:0]        slot
`ifdef TDM_DEMUX_FRAME_CNT_EN
  ,
  output logic [15:0]              frame_cnt
`endif
);

  typedef enum logic [0:0] {
    ST_HUNT   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  localparam logic [SLOT_W-1:0] c_last_slot = SLOT_W'(NUM_CH - 1);
  localparam logic [SLOT_W-1:0] c_slot_one  = SLOT_W'(1);

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic [SLOT_W-1:0]          r_slot;
  logic [SLOT_W-1:0]          w_slot_nxt;
  logic [DATA_W-1:0]          r_buf [NUM_CH-1];
  logic [NUM_CH*DATA_W-1:0]   r_out_data;
  logic                       r_out_valid;
  logic                       r_sync_err;
  logic                       r_locked;
  logic                       w_buf_we;
  logic [SLOT_W-1:0]          w_wr_idx;
  logic                       w_frame_done;
  logic                       w_err;
  logic [NUM_CH*DATA_W-1:0]   w_frame;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_HUNT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_slot_nxt   = r_slot;
    w_buf_we     = 1'b0;
    w_wr_idx     = '0;
    w_frame_done = 1'b0;
    w_err        = 1'b0;
    if (in_valid) begin
      case (r_state)
        ST_HUNT: begin
          if (in_sync) begin
            w_buf_we    = 1'b1;
            w_slot_nxt  = c_slot_one;
            w_state_nxt = ST_LOCKED;
          end
        end
        ST_LOCKED: begin
          if (in_sync && (r_slot != '0)) begin
            // Early sync restarts the frame with this sample as channel 0
            w_err      = 1'b1;
            w_buf_we   = 1'b1;
            w_slot_nxt = c_slot_one;
          end else if (!in_sync && (r_slot == '0)) begin
            w_err       = 1'b1;
            w_slot_nxt  = '0;
            w_state_nxt = ST_HUNT;
          end else if (r_slot == c_last_slot) begin
            w_frame_done = 1'b1;
            w_slot_nxt   = '0;
          end else begin
            w_buf_we   = 1'b1;
            w_wr_idx   = r_slot;
            w_slot_nxt = r_slot + c_slot_one;
          end
        end
        default: begin
          w_state_nxt = ST_HUNT;
          w_slot_nxt  = '0;
        end
      endcase
    end
  end

  // Last channel goes straight from in_data to the frame; it is never buffered
  always_comb begin
    w_frame = '0;
    for (int k = 0; k < NUM_CH - 1; k++) begin
      w_frame[k*DATA_W +: DATA_W] = r_buf[k];
    end
    w_frame[(NUM_CH-1)*DATA_W +: DATA_W] = in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slot      <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_sync_err  <= 1'b0;
      r_locked    <= 1'b0;
      for (int k = 0; k < NUM_CH - 1; k++) begin
        r_buf[k] <= '0;
      end
    end else begin
      r_slot      <= w_slot_nxt;
      r_out_valid <= w_frame_done;
      r_sync_err  <= w_err;
      r_locked    <= (w_state_nxt == ST_LOCKED);
      if (w_frame_done) begin
        r_out_data <= w_frame;
      end
      for (int k = 0; k < NUM_CH - 1; k++) begin
        if (w_buf_we && (w_wr_idx == SLOT_W'(k))) begin
          r_buf[k] <= in_data;
        end
      end
    end
  end

`ifdef TDM_DEMUX_FRAME_CNT_EN
  logic [15:0] r_frame_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_cnt <= '0;
    end else if (w_frame_done) begin
      r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  assign frame_cnt = r_frame_cnt;
`endif

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign locked    = r_locked;
  assign sync_err  = r_sync_err;
  assign slot      = r_slot;

endmodule
`default_nettype wire
